uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter HEADER, default 8'hAA; the frame start byte.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 32'd1_000_000; the inter-byte idle limit, in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port rx_data, input, 8 bits; the received byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit; a one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port cmd_valid, output, 1 bit; a decoded command is available.
REQ-008 SHALL have port cmd_ready, input, 1 bit; the consumer accepts the command.
REQ-009 SHALL have port cmd_write, output, 1 bit; 1 = write, 0 = read.
REQ-010 SHALL have port cmd_addr, output, 32 bits; the command address.
REQ-011 SHALL have port cmd_wdata, output, 32 bits; the write data, 0 for reads.
REQ-012 SHALL have port frame_err, output, 1 bit; a one-cycle pulse on a frame abort.
REQ-013 SHALL have port err_code, output, 2 bits; abort cause, valid with frame_err: 1 bad opcode, 2 checksum, 3 timeout.
REQ-014 SHALL have port overrun, output, 1 bit; a one-cycle pulse when a byte is dropped while a command is pending.

Function
REQ-015 Frame format SHALL be: HEADER, OP, A3..A0, then D3..D0 for writes only, then CHK. Multi-byte fields are MSB first.
REQ-016 OP SHALL be 8'h01 for read and 8'h02 for write; any other value is a bad opcode.
REQ-017 CHK SHALL equal the XOR of OP and every address/data byte; HEADER is excluded.
REQ-018 FSM states SHALL be IDLE, OP, ADDR, DATA, CHK, OUT. Bytes are consumed only in cycles where rx_valid=1.
REQ-019 IDLE: a byte equal to HEADER -> OP; any other byte is discarded silently with no error.
REQ-020 OP: 01/02 -> ADDR, with the byte counter cleared and the checksum accumulator loaded with OP. Any other value -> IDLE, with frame_err=1 and err_code=1.
REQ-021 ADDR: the address shift register shifts left by 8 per byte. After the 4th byte -> DATA if write, CHK if read.
REQ-022 DATA: same shifting for wdata. After the 4th byte -> CHK.
REQ-023 CHK: byte equal to the accumulator -> OUT, with cmd_valid=1 on the next cycle. Mismatch -> IDLE, with frame_err=1, err_code=2, and cmd outputs unchanged.
REQ-024 OUT: cmd_valid stays high and cmd_write/cmd_addr/cmd_wdata stay stable until the cycle where cmd_valid && cmd_ready; then cmd_valid=0 next cycle and FSM -> IDLE.
REQ-025 cmd_valid SHALL assert exactly 1 cycle after the clock edge sampling the CHK byte. Zero-wait acceptance is allowed (ready already high).
REQ-026 rx_valid in OUT: byte dropped, overrun=1 next cycle. If acceptance and rx_valid coincide, the byte is still dropped (IDLE is entered afterwards).
REQ-027 Timeout counter: cleared on every rx_valid and in IDLE/OUT, otherwise increments. It saturates at TIMEOUT_CYC and never wraps.
REQ-028 When the counter reaches TIMEOUT_CYC in OP/ADDR/DATA/CHK: FSM -> IDLE, frame_err=1, err_code=3. The partial frame is discarded.
REQ-029 If rx_valid arrives in the same cycle the timeout would fire, the byte SHALL win: it is consumed and the counter is cleared.
REQ-030 A HEADER value received mid-frame SHALL be treated as ordinary payload; there is no resynchronisation except via error or timeout.
REQ-031 frame_err, err_code, and overrun SHALL be registered outputs. err_code holds its last value between pulses.
REQ-032 For a read, cmd_wdata SHALL be forced to 0 when cmd_valid rises.

Reset
REQ-033 On rst=1 at a clock edge, the following SHALL be 0 regardless of state: FSM=IDLE, cmd_valid, cmd_write, cmd_addr, cmd_wdata, frame_err, err_code, overrun, timeout counter, checksum accumulator, and byte counter.
REQ-034 Reset mid-frame or during OUT SHALL abandon the command with no frame_err pulse. The first post-reset byte is evaluated in IDLE.

Verification
REQ-035 Read frame AA 01 10 00 00 04 15, ready=1 -> one-cycle cmd_valid, cmd_write=0, cmd_addr=32'h1000_0004, cmd_wdata=0.
REQ-036 Write frame AA 02 00 00 00 20 DE AD BE EF with CHK 02^20^DE^AD^BE^EF, ready held low 10 cycles -> cmd_valid high 11 cycles, addr=32'h20, wdata=32'hDEADBEEF, outputs stable throughout.
REQ-037 Frame AA 01 00 00 00 00 00 (bad CHK, expected 01) -> frame_err pulse, err_code=2, no cmd_valid; a following valid frame decodes correctly.
REQ-038 AA 07 -> frame_err, err_code=1. Separately, with TIMEOUT_CYC=100, send AA 02 then idle 100 cycles -> frame_err, err_code=3, FSM back in IDLE.
REQ-039 With a command pending and ready=0, a byte 55 arrives -> overrun pulse, command unchanged. rst asserted during ADDR -> all outputs 0 and no error pulse.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder
//  Purpose  : Assembles framed command bytes from a UART receiver into
//             read/write commands with a valid/ready output handshake.
//             Frame: HEADER, OP, A3..A0, [D3..D0 for writes], CHK
//             (CHK = XOR of OP and all address/data bytes).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  clock, rising edge
//    rst       in   1  synchronous active-high reset
//    rx_data   in   8  received byte
//    rx_valid  in   1  one-cycle strobe qualifying rx_data
//    cmd_valid out  1  decoded command available
//    cmd_ready in   1  consumer accepts the command
//    cmd_write out  1  1 = write, 0 = read
//    cmd_addr  out 32  command address
//    cmd_wdata out 32  write data (0 for reads)
//    frame_err out  1  one-cycle pulse on frame abort
//    err_code  out  2  abort cause: 1 bad opcode, 2 checksum, 3 timeout
//    overrun   out  1  one-cycle pulse when a byte is dropped in OUT
// ============================================================================
module uart_cmd_decoder #(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        overrun
);

  localparam logic [7:0] c_OP_READ     = 8'h01;
  localparam logic [7:0] c_OP_WRITE    = 8'h02;
  localparam logic [1:0] c_ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] c_ERR_CHK     = 2'd2;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] tmo_q, tmo_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_write_q, cmd_write_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        overrun_q, overrun_d;

  logic        w_in_frame;
  logic        w_timeout;

  // A byte arriving in the same cycle as the limit always wins over the timeout.
  assign w_in_frame = (state_q != S_IDLE) && (state_q != S_OUT);
  assign w_timeout  = w_in_frame && !rx_valid && (tmo_q == TIMEOUT_CYC);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    is_wr_d     = is_wr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;

    // Inter-byte idle counter: saturating, only runs while inside a frame.
    if (rx_valid || !w_in_frame) begin
      tmo_d = 32'd0;
    end else if (tmo_q != TIMEOUT_CYC) begin
      tmo_d = tmo_q + 32'd1;
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == HEADER)) begin
          state_d = S_OP;
        end
      end

      S_OP: begin
        if (rx_valid) begin
          if ((rx_data == c_OP_READ) || (rx_data == c_OP_WRITE)) begin
            state_d   = S_ADDR;
            cnt_d     = 2'd0;
            chk_d     = rx_data;
            is_wr_d   = (rx_data == c_OP_WRITE);
            addr_sh_d = 32'd0;
            data_sh_d = 32'd0;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = c_ERR_BAD_OP;
          end
        end else if (w_timeout) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = c_ERR_TIMEOUT;
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          addr_sh_d = {addr_sh_q[23:0], rx_data};
          chk_d     = chk_q ^ rx_data;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = is_wr_q ? S_DATA : S_CHK;
          end
        end else if (w_timeout) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = c_ERR_TIMEOUT;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          data_sh_d = {data_sh_q[23:0], rx_data};
          chk_d     = chk_q ^ rx_data;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_CHK;
          end
        end else if (w_timeout) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = c_ERR_TIMEOUT;
        end
      end

      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d     = S_OUT;
            cmd_valid_d = 1'b1;
            cmd_write_d = is_wr_q;
            cmd_addr_d  = addr_sh_q;
            cmd_wdata_d = is_wr_q ? data_sh_q : 32'd0;
          end else begin
            // Command outputs keep whatever they held before this frame.
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = c_ERR_CHK;
          end
        end else if (w_timeout) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = c_ERR_TIMEOUT;
        end
      end

      S_OUT: begin
        // No buffering: any byte arriving while a command is pending is lost,
        // including one that coincides with the accepting handshake.
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      chk_q       <= 8'd0;
      addr_sh_q   <= 32'd0;
      data_sh_q   <= 32'd0;
      is_wr_q     <= 1'b0;
      tmo_q       <= 32'd0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= 32'd0;
      cmd_wdata_q <= 32'd0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      is_wr_q     <= is_wr_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_decoder
//  Purpose  : Directed self-checking bench for uart_cmd_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        overrun;

  int n_checks;
  int n_fail;

  uart_cmd_decoder #(
    .HEADER      (8'hAA),
    .TIMEOUT_CYC (32'd100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one byte for one rising edge, returns at the falling edge just
  // after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    n_checks++; if (cmd_write !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_write got %b exp 0", cmd_write); end
    n_checks++; if (cmd_addr !== 32'd0) begin n_fail++; $display("FAIL reset_cmd_addr got %h exp 0", cmd_addr); end
    n_checks++; if (cmd_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_cmd_wdata got %h exp 0", cmd_wdata); end
    n_checks++; if ({frame_err, err_code, overrun} !== 4'b0) begin n_fail++; $display("FAIL reset_err_flags got %b exp 0000", {frame_err, err_code, overrun}); end
  endtask

  task automatic test_read();
    cmd_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h15);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid got %b exp 1", cmd_valid); end
    n_checks++; if (cmd_write !== 1'b0) begin n_fail++; $display("FAIL read_write got %b exp 0", cmd_write); end
    n_checks++; if (cmd_addr !== 32'h1000_0004) begin n_fail++; $display("FAIL read_addr got %h exp 10000004", cmd_addr); end
    n_checks++; if (cmd_wdata !== 32'd0) begin n_fail++; $display("FAIL read_wdata got %h exp 0", cmd_wdata); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_one_cycle got %b exp 0", cmd_valid); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_write_backpressure();
    cmd_ready = 1'b0;
    send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h00);   // 02^20^DE^AD^BE^EF = 00
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if ((cmd_valid !== 1'b1) || (cmd_write !== 1'b1) || (cmd_addr !== 32'h20) || (cmd_wdata !== 32'hDEAD_BEEF)) begin
        n_fail++;
        $display("FAIL write_hold cycle %0d got v=%b w=%b a=%h d=%h exp v=1 w=1 a=00000020 d=deadbeef",
                 i, cmd_valid, cmd_write, cmd_addr, cmd_wdata);
      end
      if (i == 10) cmd_ready = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL write_release got %b exp 0", cmd_valid); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_bad_chk();
    cmd_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL chk_err_pulse got %b exp 1", frame_err); end
    n_checks++; if (err_code !== 2'd2) begin n_fail++; $display("FAIL chk_err_code got %0d exp 2", err_code); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL chk_no_valid got %b exp 0", cmd_valid); end
    n_checks++; if ((cmd_addr !== 32'h20) || (cmd_wdata !== 32'hDEAD_BEEF)) begin n_fail++; $display("FAIL chk_outputs_kept got a=%h d=%h exp a=00000020 d=deadbeef", cmd_addr, cmd_wdata); end
    @(negedge clk);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL chk_err_one_cycle got %b exp 0", frame_err); end
    // 01^12^34^56^78 = 09
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h09);
    n_checks++; if ((cmd_valid !== 1'b1) || (cmd_addr !== 32'h1234_5678) || (cmd_wdata !== 32'd0)) begin n_fail++; $display("FAIL chk_recover got v=%b a=%h d=%h exp v=1 a=12345678 d=0", cmd_valid, cmd_addr, cmd_wdata); end
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_bad_op();
    send_byte(8'h33);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL idle_noise_err got %b exp 0", frame_err); end
    send_byte(8'hAA); send_byte(8'h07);
    n_checks++; if ((frame_err !== 1'b1) || (err_code !== 2'd1)) begin n_fail++; $display("FAIL bad_op got fe=%b ec=%0d exp fe=1 ec=1", frame_err, err_code); end
    @(negedge clk);
    n_checks++; if ((frame_err !== 1'b0) || (err_code !== 2'd1)) begin n_fail++; $display("FAIL bad_op_hold got fe=%b ec=%0d exp fe=0 ec=1", frame_err, err_code); end
  endtask

  task automatic test_timeout();
    int  seen_at;
    logic got_valid;
    seen_at   = -1;
    got_valid = 1'b0;
    send_byte(8'hAA); send_byte(8'h02);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (cmd_valid) got_valid = 1'b1;
      if (frame_err === 1'b1) begin
        seen_at = c;
        break;
      end
    end
    n_checks++; if ((seen_at < 99) || (seen_at > 102)) begin n_fail++; $display("FAIL timeout_latency got %0d cycles exp 99..102", seen_at); end
    n_checks++; if (err_code !== 2'd3) begin n_fail++; $display("FAIL timeout_code got %0d exp 3", err_code); end
    n_checks++; if (got_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_no_valid got %b exp 0", got_valid); end
    cmd_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h15);
    n_checks++; if ((cmd_valid !== 1'b1) || (cmd_addr !== 32'h1000_0004)) begin n_fail++; $display("FAIL timeout_recover got v=%b a=%h exp v=1 a=10000004", cmd_valid, cmd_addr); end
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_overrun();
    cmd_ready = 1'b0;
    // 01^CA^FE^00^01 = 34
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h34);
    n_checks++; if ((cmd_valid !== 1'b1) || (cmd_addr !== 32'hCAFE_0001)) begin n_fail++; $display("FAIL ovr_pending got v=%b a=%h exp v=1 a=cafe0001", cmd_valid, cmd_addr); end
    send_byte(8'h55);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
    n_checks++; if ((cmd_valid !== 1'b1) || (cmd_addr !== 32'hCAFE_0001) || (cmd_write !== 1'b0)) begin n_fail++; $display("FAIL ovr_cmd_kept got v=%b w=%b a=%h exp v=1 w=0 a=cafe0001", cmd_valid, cmd_write, cmd_addr); end
    @(negedge clk);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
    // Header byte coincident with acceptance must be dropped.
    cmd_ready = 1'b1;
    rx_data   = 8'hAA;
    rx_valid  = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    n_checks++; if ((cmd_valid !== 1'b0) || (overrun !== 1'b1)) begin n_fail++; $display("FAIL ovr_coincide got v=%b ovr=%b exp v=0 ovr=1", cmd_valid, overrun); end
    cmd_ready = 1'b1;
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h15);
    n_checks++; if ((cmd_valid !== 1'b0) || (frame_err !== 1'b0)) begin n_fail++; $display("FAIL ovr_header_dropped got v=%b fe=%b exp v=0 fe=0", cmd_valid, frame_err); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_header_mid_frame();
    cmd_ready = 1'b1;
    // 01^AA^AA^AA^AA = 01
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hAA);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h01);
    n_checks++; if ((cmd_valid !== 1'b1) || (cmd_addr !== 32'hAAAA_AAAA)) begin n_fail++; $display("FAIL hdr_payload got v=%b a=%h exp v=1 a=aaaaaaaa", cmd_valid, cmd_addr); end
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic err_seen;
    err_seen = 1'b0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata, frame_err, err_code, overrun} !== 70'd0) begin n_fail++; $display("FAIL rst_mid_outputs got v=%b w=%b a=%h d=%h fe=%b ec=%0d ovr=%b exp all 0", cmd_valid, cmd_write, cmd_addr, cmd_wdata, frame_err, err_code, overrun); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (frame_err) err_seen = 1'b1;
    end
    n_checks++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_err got %b exp 0", err_seen); end
    cmd_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h15);
    n_checks++; if ((cmd_valid !== 1'b1) || (cmd_addr !== 32'h1000_0004)) begin n_fail++; $display("FAIL rst_mid_recover got v=%b a=%h exp v=1 a=10000004", cmd_valid, cmd_addr); end
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    test_reset();
    test_read();
    test_write_backpressure();
    test_bad_chk();
    test_bad_op();
    test_timeout();
    test_overrun();
    test_header_mid_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
